// File: rtl/fp32_tx_pkg.sv
// rtl/fp32_tx_pkg.sv - shared types, constants and byte-order helpers for the FP32 UART sender
package fp32_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int BYTES_PER_WORD       = 4;

    function automatic logic [7:0] lead_byte(input logic [31:0] word, input logic lsb_first);
        return lsb_first ? word[7:0] : word[31:24];
    endfunction

    // Drops the byte just handed to the serializer so the next one sits in the lead position.
    function automatic logic [31:0] trail_bytes(input logic [31:0] word, input logic lsb_first);
        return lsb_first ? {8'h00, word[31:8]} : {word[23:0], 8'h00};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; a start on the last stop-bit cycle chains the next byte gap-free
module uart_tx_byte
    import fp32_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        baud_end;
    logic        load;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign load     = start && ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_START;
            ST_START: if (baud_end) state_next = ST_DATA;
            ST_DATA:  if (baud_end && (bit_idx == 3'd7)) state_next = ST_STOP;
            ST_STOP:  if (baud_end) state_next = start ? ST_START : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            ST_IDLE:  busy = 1'b0;
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg[0];
            ST_STOP:  done = baud_end;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || (state == ST_IDLE) || baud_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else if (load) begin
            bit_idx <= '0;
            shreg   <= data;
        end else if ((state == ST_DATA) && baud_end) begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {1'b0, shreg[7:1]};
        end
    end

endmodule

// File: rtl/fp32_result_tx.sv
// rtl/fp32_result_tx.sv - latches an FP32 word and sends its four bytes back-to-back over a UART line
module fp32_result_tx
    import fp32_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter bit LSB_BYTE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    logic [31:0] word_sr;
    logic [1:0]  byte_idx;
    logic        byte_start;
    logic        byte_busy;
    logic        byte_done;
    logic        transfer;
    logic        last_byte;
    logic [7:0]  byte_data;

    assign in_ready   = ~byte_busy;
    assign busy       = byte_busy;
    assign transfer   = in_valid && in_ready;
    assign last_byte  = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign byte_start = transfer || (byte_done && !last_byte);
    assign done       = byte_done && last_byte;
    // On the accept edge the first byte comes straight from in_data; word_sr holds only what remains.
    assign byte_data  = lead_byte(transfer ? in_data : word_sr, LSB_BYTE_FIRST);

    always_ff @(posedge clk) begin
        if (reset) begin
            word_sr  <= '0;
            byte_idx <= '0;
        end else if (transfer) begin
            word_sr  <= trail_bytes(in_data, LSB_BYTE_FIRST);
            byte_idx <= '0;
        end else if (byte_done) begin
            word_sr  <= trail_bytes(word_sr, LSB_BYTE_FIRST);
            byte_idx <= byte_idx + 2'd1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .reset(reset),
        .start(byte_start),
        .data (byte_data),
        .tx   (tx),
        .busy (byte_busy),
        .done (byte_done)
    );

endmodule

// File: tb/tb_fp32_result_tx.sv
// tb/tb_fp32_result_tx.sv - scoreboard bench: two instances (byte orders) with a UART line decoder
module tb_fp32_result_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        rdy0, rdy1, tx0, tx1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    fp32_result_tx #(.CLKS_PER_BIT(CPB), .LSB_BYTE_FIRST(1'b1)) u_dut_lsb (
        .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0),
        .in_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
    );

    fp32_result_tx #(.CLKS_PER_BIT(CPB), .LSB_BYTE_FIRST(1'b0)) u_dut_msb (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples each bit mid-cell, checks start width and stop level, pops the scoreboard.
    logic       act[2];
    int         idx[2];
    int         low[2];
    logic [7:0] rxb[2];
    logic       stopb[2];

    initial begin
        for (int l = 0; l < 2; l++) begin
            act[l] = 1'b0; idx[l] = 0; low[l] = 0; rxb[l] = '0; stopb[l] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            logic       t;
            logic [7:0] e;
            t = (l == 0) ? tx0 : tx1;
            if (reset) begin
                act[l] = 1'b0;
            end else if (!act[l]) begin
                if (t === 1'b0) begin
                    act[l] = 1'b1; idx[l] = 0; low[l] = 1;
                end
            end else begin
                idx[l]++;
                if (idx[l] < CPB && t === 1'b0) low[l]++;
                if (idx[l] >= CPB && idx[l] < 9 * CPB && (idx[l] % CPB) == CPB / 2)
                    rxb[l] = {t, rxb[l][7:1]};
                if (idx[l] == 9 * CPB + CPB / 2) stopb[l] = t;
                if (idx[l] == 10 * CPB - 1) begin
                    act[l] = 1'b0;
                    e = 8'hxx;
                    if (l == 0) begin
                        if (q0.size() > 0) e = q0.pop_front();
                    end else begin
                        if (q1.size() > 0) e = q1.pop_front();
                    end
                    check($sformatf("rx_byte_lane%0d", l), {24'h0, rxb[l]}, {24'h0, e});
                    check($sformatf("start_width_lane%0d", l), low[l], CPB);
                    check($sformatf("stop_level_lane%0d", l), {31'h0, stopb[l]}, 32'h1);
                end
            end
        end
    end

    task automatic push_word(input int lane, input logic [31:0] w, input logic lsb_first);
        logic [31:0] s;
        s = w;
        for (int b = 0; b < 4; b++) begin
            if (lane == 0) q0.push_back(lsb_first ? s[7:0] : s[31:24]);
            else           q1.push_back(lsb_first ? s[7:0] : s[31:24]);
            s = lsb_first ? {8'h00, s[31:8]} : {s[23:0], 8'h00};
        end
    endtask

    task automatic accept(input int lane, input logic [31:0] w);
        if (lane == 0) begin v0 = 1'b1; d0 = w; end
        else           begin v1 = 1'b1; d1 = w; end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic wait_done(input int lane, input int n0, output int n);
        n = n0;
        while ((((lane == 0) ? done0 : done1) !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int dcnt;
        int hi;

        repeat (3) @(negedge clk);
        check("reset_tx", {31'h0, tx0}, 32'h1);
        check("reset_ready", {31'h0, rdy0}, 32'h1);
        check("reset_busy", {31'h0, busy0}, 32'h0);
        check("reset_done", {31'h0, done0}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        push_word(0, 32'h3F800000, 1'b1);
        accept(0, 32'h3F800000);
        check("tx_low_after_accept", {31'h0, tx0}, 32'h0);
        check("busy_in_word", {31'h0, busy0}, 32'h1);
        check("ready_low_in_word", {31'h0, rdy0}, 32'h0);
        wait_done(0, 1, n);
        check("done_cycle_lsb", n, 160);
        @(negedge clk);
        check("ready_after_done", {31'h0, rdy0}, 32'h1);
        check("done_single_pulse", {31'h0, done0}, 32'h0);
        check("busy_after_done", {31'h0, busy0}, 32'h0);

        push_word(1, 32'hC0490FDB, 1'b0);
        accept(1, 32'hC0490FDB);
        check("tx_low_after_accept_msb", {31'h0, tx1}, 32'h0);
        wait_done(1, 1, n);
        check("done_cycle_msb", n, 160);
        @(negedge clk);

        push_word(0, 32'h00000000, 1'b1);
        push_word(0, 32'hFFFFFFFF, 1'b1);
        v0 = 1'b1; d0 = 32'h00000000;
        @(negedge clk);
        d0 = 32'hFFFFFFFF;
        check("b2b_first_accepted", {31'h0, tx0}, 32'h0);
        wait_done(0, 1, n);
        check("b2b_done_first", n, 160);
        @(negedge clk);
        check("b2b_idle_ready", {31'h0, rdy0}, 32'h1);
        check("b2b_idle_tx", {31'h0, tx0}, 32'h1);
        @(negedge clk);
        v0 = 1'b0;
        check("b2b_second_accepted", {31'h0, tx0}, 32'h0);
        check("b2b_second_busy", {31'h0, rdy0}, 32'h0);
        wait_done(0, 1, n);
        check("b2b_done_second", n, 160);
        @(negedge clk);

        push_word(0, 32'hAABBCCDD, 1'b1);
        accept(0, 32'hAABBCCDD);
        dcnt = 0;
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk);
            if (done0 === 1'b1) dcnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'h0, tx0}, 32'h1);
        check("abort_ready", {31'h0, rdy0}, 32'h1);
        check("abort_busy", {31'h0, busy0}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 === 1'b1) dcnt++;
            if (tx0 === 1'b1) hi++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_no_resume", hi, 20);

        push_word(0, 32'h12345678, 1'b1);
        accept(0, 32'h12345678);
        wait_done(0, 1, n);
        check("after_abort_done", n, 160);
        @(negedge clk);

        push_word(0, 32'h40000000, 1'b1);
        accept(0, 32'h40000000);
        n = 1;
        for (int c = 0; c < 100; c++) begin
            v0 = c[0];
            d0 = 32'hDEADBEEF;
            @(negedge clk);
            n++;
        end
        v0 = 1'b0;
        wait_done(0, n, n);
        check("ignore_busy_done", n, 160);
        @(negedge clk);

        reset = 1'b1;
        v0 = 1'b1;
        d0 = 32'h55555555;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        v0 = 1'b0;
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx0 === 1'b1) hi++;
        end
        check("reset_valid_tx_idle", hi, 10);
        check("reset_valid_ready", {31'h0, rdy0}, 32'h1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty_lsb", q0.size(), 0);
        check("scoreboard_empty_msb", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
